// File: rtl/ffio_analog_inp.sv
// Main-bus input slave: emulated 4-channel 8-bit SAR ADC
// plus synchronized digital switch port.
module ffio_analog_inp #(
  parameter int CONV_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [22:0] ad,
  input  logic        as,
  input  logic        rw,
  input  logic        lds,
  input  logic        uds,
  input  logic [15:0] od,
  input  logic [7:0]  an0,
  input  logic [7:0]  an1,
  input  logic [7:0]  an2,
  input  logic [7:0]  an3,
  input  logic [15:0] sw,
  output logic        inp_dtack,
  output logic        inp_dv,
  output logic [15:0] inp_dt
);

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  localparam logic [7:0] CNT_LOAD = 8'(CONV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       ch_q, ch_d;
  logic [7:0]       result_q, result_d;
  logic             eoc_q, eoc_d;
  logic             wr_seen_q, wr_seen_d;
  logic             dtack_q;
  logic [15:0]      sw_s1_q, sw_s2_q;
  logic [3:0][7:0]  an_s1_q, an_s2_q;

  logic acc;
  logic cs_adc;
  logic cs_sw;
  logic cs;
  logic start;
  logic unused_od;

  assign unused_od = ^od;

  assign acc    = as & (lds | uds);
  assign cs_adc = acc & (ad[22:4] == 19'h52000);
  assign cs_sw  = acc & (ad == 23'h4A4000);
  assign cs     = cs_adc | cs_sw;
  assign start  = cs_adc & rw & ~wr_seen_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    result_d  = result_q;
    eoc_d     = eoc_q;
    wr_seen_d = wr_seen_q;
    if (!as) begin
      wr_seen_d = 1'b0;
    end else if (start) begin
      wr_seen_d = 1'b1;
    end
    // a new start always wins, even on the completing cycle
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ch_d    = ad[1:0];
          cnt_d   = CNT_LOAD;
          eoc_d   = 1'b0;
          state_d = CONV;
        end
      end
      CONV: begin
        if (start) begin
          ch_d  = ad[1:0];
          cnt_d = CNT_LOAD;
          eoc_d = 1'b0;
        end else if (cnt_q == 8'd0) begin
          result_d = an_s2_q[ch_q];
          eoc_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      ch_q      <= 2'd0;
      result_q  <= 8'h00;
      eoc_q     <= 1'b1;
      wr_seen_q <= 1'b0;
      dtack_q   <= 1'b0;
      sw_s1_q   <= 16'hFFFF;
      sw_s2_q   <= 16'hFFFF;
      an_s1_q   <= '0;
      an_s2_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      result_q  <= result_d;
      eoc_q     <= eoc_d;
      wr_seen_q <= wr_seen_d;
      dtack_q   <= cs;
      sw_s1_q   <= sw;
      sw_s2_q   <= sw_s1_q;
      an_s1_q   <= {an3, an2, an1, an0};
      an_s2_q   <= an_s1_q;
    end
  end

  assign inp_dtack = dtack_q;
  assign inp_dv    = cs & ~rw & reset_n;

  always_comb begin
    inp_dt = 16'h0000;
    if (inp_dv) begin
      if (cs_sw) begin
        inp_dt = sw_s2_q;
      end else begin
        inp_dt = {7'b0, eoc_q, result_q};
      end
    end
  end

endmodule

// File: tb/tb_ffio_analog_inp.sv
// Bench for ffio_analog_inp: directed scenarios then random
// traffic against a cycle-level behavioural model.
module tb_ffio_analog_inp;

  localparam int CONV = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [22:0] ad;
  logic        as, rw, lds, uds;
  logic [15:0] od;
  logic [7:0]  an0, an1, an2, an3;
  logic [15:0] sw;
  logic        inp_dtack, inp_dv;
  logic [15:0] inp_dt;

  int errors = 0;
  int checks = 0;

  ffio_analog_inp #(.CONV_CYCLES(CONV)) dut (
    .clk(clk), .reset_n(reset_n), .ad(ad), .as(as), .rw(rw),
    .lds(lds), .uds(uds), .od(od),
    .an0(an0), .an1(an1), .an2(an2), .an3(an3), .sw(sw),
    .inp_dtack(inp_dtack), .inp_dv(inp_dv), .inp_dt(inp_dt)
  );

  always #5 clk = ~clk;

  // behavioural model state
  int          edges;
  bit          busy_m;
  int          deadline_m;
  int          ch_m;
  logic [7:0]  res_m;
  bit          seen_m;
  bit          prev_cs_m;
  logic [15:0] sw_d1_m, sw_d2_m;
  logic [7:0]  an_d1_m[4];
  logic [7:0]  an_d2_m[4];

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy_m    = 0;
    res_m     = 8'h00;
    seen_m    = 0;
    prev_cs_m = 0;
    sw_d1_m   = 16'hFFFF;
    sw_d2_m   = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      an_d1_m[i] = 8'h00;
      an_d2_m[i] = 8'h00;
    end
  endtask

  function automatic logic [7:0] an_now(input int i);
    case (i)
      0: return an0;
      1: return an1;
      2: return an2;
      default: return an3;
    endcase
  endfunction

  // one bus cycle: drive, check mid-cycle, clock, advance model
  task automatic bus(input string tag, input bit a, input bit w,
                     input logic [23:0] baddr);
    bit adc, swc, cs, dv, st;
    logic [15:0] dt;
    as  = a;
    rw  = w;
    lds = a;
    uds = a;
    ad  = baddr[23:1];
    od  = 16'($urandom);
    adc = a && baddr >= 24'hA40000 && baddr <= 24'hA4001F;
    swc = a && baddr[23:1] == 23'h4A4000;
    cs  = adc || swc;
    dv  = cs && !w;
    dt  = !dv ? 16'h0000 :
          swc ? sw_d2_m : {7'b0, !busy_m, res_m};
    #4;
    chk({tag, ".dv"}, 16'(inp_dv), 16'(dv));
    chk({tag, ".dt"}, inp_dt, dt);
    chk({tag, ".dtack"}, 16'(inp_dtack), 16'(prev_cs_m));
    st = adc && w && !seen_m;
    @(posedge clk);
    edges++;
    if (st) begin
      busy_m     = 1;
      deadline_m = edges + CONV;
      ch_m       = int'(baddr[2:1]);
    end else if (busy_m && edges == deadline_m) begin
      busy_m = 0;
      res_m  = an_d2_m[ch_m];
    end
    if (st) seen_m = 1;
    if (!a) seen_m = 0;
    prev_cs_m = cs;
    sw_d2_m   = sw_d1_m;
    sw_d1_m   = sw;
    for (int i = 0; i < 4; i++) begin
      an_d2_m[i] = an_d1_m[i];
      an_d1_m[i] = an_now(i);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus("idle", 0, 0, 24'h0);
  endtask

  task automatic poll(input int n);
    for (int i = 0; i < n; i++) bus("poll", 1, 0, 24'hA40000);
  endtask

  initial begin
    edges   = 0;
    reset_n = 1'b0;
    as = 0; rw = 0; lds = 0; uds = 0; ad = '0; od = '0;
    an0 = 0; an1 = 0; an2 = 0; an3 = 0;
    sw  = 16'hFFFF;
    model_reset();
    as = 1; lds = 1; ad = 23'h520000;
    #3;
    chk("rst.dtack", 16'(inp_dtack), 16'h0);
    chk("rst.dv", 16'(inp_dv), 16'h0);
    chk("rst.dt", inp_dt, 16'h0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // reset value read and dtack timing
    idle(1);
    bus("rd0", 1, 0, 24'hA40000);
    bus("rd1", 1, 0, 24'hA40000);
    idle(2);

    // basic conversion on channel 2
    an2 = 8'h5A;
    idle(3);
    bus("wr2", 1, 1, 24'hA40004);
    idle(1);
    poll(CONV + 4);
    chk("ch2.res", inp_dt, 16'h015A);
    idle(1);

    // held write starts exactly one conversion
    an1 = 8'h33;
    idle(3);
    for (int i = 0; i < 10; i++) bus("hold", 1, 1, 24'hA40002);
    poll(CONV);
    chk("ch1.res", inp_dt, 16'h0133);
    idle(1);

    // restart discards the first conversion
    an0 = 8'h11;
    an3 = 8'hEE;
    idle(3);
    bus("wr0", 1, 1, 24'hA40000);
    idle(29);
    bus("wr3", 1, 1, 24'hA40006);
    idle(1);
    poll(CONV + 4);
    chk("ch3.res", inp_dt, 16'h01EE);
    idle(1);

    // start on the completing edge wins
    an1 = 8'h44;
    bus("wrc", 1, 1, 24'hA40002);
    idle(CONV - 1);
    bus("wrw", 1, 1, 24'hA40000);
    poll(CONV + 2);
    chk("coll.res", inp_dt, 16'h0111);
    idle(1);

    // switch port
    sw = 16'hFFFE;
    idle(3);
    bus("swrd", 1, 0, 24'h948000);
    chk("sw.val", inp_dt, 16'hFFFE);
    bus("swwr", 1, 1, 24'h948000);
    bus("swad", 1, 0, 24'hA40000);
    idle(1);

    // reset in the middle of a conversion
    bus("wrr", 1, 1, 24'hA40002);
    idle(19);
    bus("prerst", 1, 0, 24'hA40000);
    as = 1; lds = 1; rw = 0; ad = 23'h520000;
    reset_n = 1'b0;
    #1;
    chk("mrst.dtack", 16'(inp_dtack), 16'h0);
    chk("mrst.dv", 16'(inp_dv), 16'h0);
    chk("mrst.dt", inp_dt, 16'h0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(1);
    bus("post", 1, 0, 24'hA40000);
    chk("post.val", inp_dt, 16'h0100);
    idle(1);
    bus("oor", 1, 0, 24'h014000);
    bus("oor2", 1, 1, 24'h014000);
    idle(2);

    // random traffic
    for (int it = 0; it < 1500; it++) begin
      int op;
      logic [23:0] a;
      op = int'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        an0 = 8'($urandom); an1 = 8'($urandom);
        an2 = 8'($urandom); an3 = 8'($urandom);
      end
      a = 24'hA40000 | 24'({$urandom_range(0, 15), 1'b0});
      case (op)
        0: bus("r.wr", 1, 1, a);
        1: bus("r.sww", 1, 1, 24'h948000);
        2, 3, 4: bus("r.rd", 1, 0, a);
        5: bus("r.sw", 1, 0, 24'h948000);
        6: bus("r.oor", 1, ($urandom & 1) != 0,
               24'($urandom) & 24'h7FFFFE);
        default: bus("r.idle", 0, 0, 24'h0);
      endcase
    end
    idle(CONV + 2);
    poll(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ffio_analog_inp.md
# ffio_analog_inp

Bus slave on the main 68000 bus that serves the analog trackball/stick ADC and the digital input port. It feeds the `inp_dtack` / `inp_dv` / `inp_dt` inputs of the main CPU block. It emulates an 8-bit, 4-channel successive-approximation ADC: a write starts a timed conversion, and a read returns the latched result plus an end-of-conversion flag. It also returns synchronized player switches.

## Interface

Parameters:
- `CONV_CYCLES`, default 64: clock cycles from conversion start to result latch. Legal range is 2..255.

Ports:
- `clk` in 1: bus clock, the same clock the program ROM and work RAM use.
- `reset_n` in 1: asynchronous, active-low reset.
- `ad` in 23: CPU word address, equal to byte address [23:1].
- `as` in 1: address strobe, active-high.
- `rw` in 1: 1 = write, 0 = read.
- `lds`, `uds` in 1: byte strobes, active-high.
- `od` in 16: CPU write data. It is ignored for ADC writes; only the address selects the channel.
- `an0`, `an1`, `an2`, `an3` in 8: analog channel levels, asynchronous to `clk`.
- `sw` in 16: raw digital switches, active-low, asynchronous.
- `inp_dtack` out 1: registered acknowledge.
- `inp_dv` out 1: read data valid.
- `inp_dt` out 16: read data.

## Operation

Address decode (the access term is `as & (lds|uds)`):
- `cs_adc`: `ad[22:4]` == 19'h52000, byte range $A40000-$A4001F. The channel is `ad[1:0]`.
- `cs_sw`: `ad[22:0]` == 23'h4A4000, byte address $948000.
- `cs = cs_adc | cs_sw`.

Switch path:
- `sw` passes through a 2-flop synchronizer, giving `sw_s`.
- A read of `cs_sw` returns `sw_s`.
- Writes to `cs_sw` are ignored but still acknowledged.

ADC state machine, with states IDLE and CONV:
- Start trigger: the first cycle of a write access to `cs_adc`. A `wr_seen` flag is set on that cycle and cleared when `as` is 0. A held strobe therefore starts exactly one conversion.
- IDLE, on start: set `ch <= ad[1:0]`, `cnt <= CONV_CYCLES-1`, `eoc <= 0`, then go to CONV.
- CONV: decrement `cnt` each cycle. When `cnt` == 0, set `result <= an[ch]`, `eoc <= 1`, then go to IDLE.
- `an[ch]` is sampled through a 2-flop synchronizer that runs on all four channels continuously. The result reflects the level at the end of the conversion, not at its start.
- Start while in CONV: restart. Load the new `ch`, reload `cnt`, and keep `eoc` = 0. The old conversion is discarded and `result` is unchanged.

ADC read (any channel address):
- `inp_dt` = {7'b0, `eoc`, `result`}.
- A read during CONV returns the previous `result` with `eoc` = 0.

Output rules:
- `inp_dv` = `cs & ~rw` (combinational).
- `inp_dt` = 16'h0000 when `inp_dv` = 0.

## Timing

- `inp_dtack` is registered: `inp_dtack <= cs` each `clk` edge.
  - It rises one cycle after the access term asserts.
  - It falls one cycle after `as` drops.
  - There is no extra wait state, including for ADC reads during CONV.
- `inp_dv` / `inp_dt`: valid in the same cycle as `cs`.
- Conversion latency: the start trigger happens in cycle 0, and `eoc` reads 1 from cycle `CONV_CYCLES` onward.
- Switch latency: 2 cycles from a `sw` change to visible read data.
- Reset values (while `reset_n` = 0, asynchronously):
  - `inp_dtack` = 0, `inp_dv` = 0, `inp_dt` = 0.
  - State = IDLE, `cnt` = 0, `ch` = 0, `result` = 8'h00, `eoc` = 1, `wr_seen` = 0.
  - Synchronizers = 16'hFFFF for the switch path and 8'h00 for each analog channel.
- Reset asserted mid-conversion aborts the conversion. After release, an ADC read returns 16'h0100.
- Simultaneous completion (`cnt` == 0) and start: the start wins. `result` is not updated, and a fresh conversion begins.
- Simultaneous read and completion: that read returns the old `result` with `eoc` = 0. The next cycle shows the new values.
- Accesses outside both ranges: all outputs stay 0, and ADC state is unaffected.

## Test plan

- Reset release, then read $A40000 → `inp_dtack` rises 1 cycle after `as`, and `inp_dt` = 16'h0100.
- Set `an2` = 8'h5A, write $A40004, then poll $A40000 → `inp_dt` = 16'h0000 through cycle 63, then 16'h015A from cycle 64 (`CONV_CYCLES` = 64).
- Write to ch1 held for 10 cycles with `an1` = 8'h33 → exactly one conversion starts, and the result is 16'h0133 at cycle 64.
- Write ch0 (`an0` = 8'h11), write ch3 (`an3` = 8'hEE) at cycle 30 → `eoc` stays 0 until cycle 94, then `inp_dt` = 16'h01EE. The value 8'h11 is never latched.
- Set `sw` = 16'hFFFE, read $948000 → `inp_dt` = 16'hFFFE. A write to $948000 → `inp_dtack` asserts, `inp_dv` = 0, and the ADC state is unchanged.
- Assert `reset_n` low at cycle 20 of a conversion → `inp_dtack` = 0 immediately. After release, a read returns 16'h0100, and an access to $014000 gives `inp_dtack` = 0 and `inp_dv` = 0.
